// File: rtl/seg_pkg.sv
// Shared segment constants and nibble-to-pattern decode for the multiplexed 7-segment driver.
// Patterns are active-low with bit 0 = segment a through bit 6 = segment g.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Index 15 first, down to index 0; A-F all render as a dash.
  localparam logic [15:0][6:0] SEG_PATTERNS = {
    SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH,
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] nibble);
    return SEG_PATTERNS[nibble];
  endfunction

endpackage

// File: rtl/seg_decoder.sv
// Combinational nibble decoder used on the currently scanned digit.
module seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = bcd_to_seg(nibble);

endmodule

// File: rtl/seg_display_scan.sv
// Multiplexed common-anode 7-segment scanner with blink, leading-zero blanking and shadowed loads.
// Define SEG_DP_EN to add the decimal-point input dp and output dp_n.
module seg_display_scan
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_HZ     = 100000000,
  parameter int REFRESH_HZ = 1000,
  parameter int BLINK_HZ   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    blank_lz,
`ifdef SEG_DP_EN
  input  logic [NUM_DIGITS-1:0]   dp,
  output logic                    dp_n,
`endif
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int SCAN_DIV  = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
  localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
  localparam int SCAN_W    = $clog2(SCAN_DIV) + 1;
  localparam int BLINK_W   = $clog2(BLINK_DIV) + 1;
  localparam int IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  if (SCAN_DIV < 1) begin : g_bad_scan_div
    $error("seg_display_scan: scan divisor must be at least 1");
  end
  if (BLINK_DIV < 1) begin : g_bad_blink_div
    $error("seg_display_scan: blink divisor must be at least 1");
  end

  logic [SCAN_W-1:0]       scan_cnt_q, scan_cnt_d;
  logic [BLINK_W-1:0]      blink_cnt_q, blink_cnt_d;
  logic                    phase_on_q, phase_on_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] shadow_val_q, shadow_val_d;
  logic [NUM_DIGITS-1:0]   shadow_mask_q, shadow_mask_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    scan_tick;
  logic                    blink_tick;
  logic [3:0]              cur_nibble;
  logic [6:0]              dec_seg;
  logic [NUM_DIGITS-1:0]   lz_mask;
  logic                    lz_run;
  logic                    blink_off;
  logic                    blank;

  seg_decoder u_decoder (
    .nibble (cur_nibble),
    .seg    (dec_seg)
  );

  assign scan_tick  = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
  assign blink_tick = (blink_cnt_q == BLINK_W'(BLINK_DIV - 1));
  assign cur_nibble = shadow_val_q[idx_q*4 +: 4];
  assign blink_off  = shadow_mask_q[idx_q] && !phase_on_q;

  // A digit is a leading zero when it and every higher digit are zero; digit 0 never is.
  always_comb begin
    lz_mask = '0;
    lz_run  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      lz_run     = lz_run && (shadow_val_q[i*4 +: 4] == 4'd0);
      lz_mask[i] = lz_run;
    end
  end

  assign blank = blink_off || (blank_lz && lz_mask[idx_q]);

  always_comb begin
    scan_cnt_d    = scan_tick ? '0 : scan_cnt_q + 1'b1;
    blink_cnt_d   = blink_tick ? '0 : blink_cnt_q + 1'b1;
    phase_on_d    = blink_tick ? !phase_on_q : phase_on_q;
    shadow_val_d  = load ? value : shadow_val_q;
    shadow_mask_d = load ? blink_mask : shadow_mask_q;
    idx_d         = idx_q;
    seg_d         = seg_q;
    an_d          = an_q;
    // The tick latches the digit at the current index, then moves the index on.
    if (scan_tick) begin
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
      seg_d = blank ? SEG_BLANK : dec_seg;
      an_d  = ~(NUM_DIGITS'(1) << idx_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_q    <= '0;
      blink_cnt_q   <= '0;
      phase_on_q    <= 1'b1;
      idx_q         <= '0;
      shadow_val_q  <= '0;
      shadow_mask_q <= '0;
      seg_q         <= SEG_BLANK;
      an_q          <= '1;
    end else begin
      scan_cnt_q    <= scan_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      phase_on_q    <= phase_on_d;
      idx_q         <= idx_d;
      shadow_val_q  <= shadow_val_d;
      shadow_mask_q <= shadow_mask_d;
      seg_q         <= seg_d;
      an_q          <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

`ifdef SEG_DP_EN
  logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
  logic                  dp_n_q, dp_n_d;

  always_comb begin
    shadow_dp_d = load ? dp : shadow_dp_q;
    dp_n_d      = dp_n_q;
    if (scan_tick) begin
      dp_n_d = !(shadow_dp_q[idx_q] && !blink_off);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_dp_q <= '0;
      dp_n_q      <= 1'b1;
    end else begin
      shadow_dp_q <= shadow_dp_d;
      dp_n_q      <= dp_n_d;
    end
  end

  assign dp_n = dp_n_q;
`endif

endmodule

// File: tb/tb_seg_display_scan.sv
// Scoreboard bench for seg_display_scan: stimulus queues expected digit outputs,
// a monitor pops and compares whenever the anode pattern changes or a reset is requested.
module tb_seg_display_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic        load;
  logic [3:0]  blink_mask;
  logic        blank_lz;
  logic [6:0]  seg;
  logic [3:0]  an;

  always #5 clk = ~clk;

  seg_display_scan #(
    .NUM_DIGITS (4),
    .CLK_HZ     (1000),
    .REFRESH_HZ (50),
    .BLINK_HZ   (10)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .load       (load),
    .blink_mask (blink_mask),
    .blank_lz   (blank_lz),
    .seg        (seg),
    .an         (an)
  );

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    string      name;
  } exp_t;

  exp_t        expQ[$];
  int          checkCnt  = 0;
  int          passCnt   = 0;
  int          reqCount  = 0;
  int          reqSeen   = 0;
  bit          monOn     = 1'b0;
  logic [3:0]  prevAn    = 4'h0;
  logic [15:0] shVal;
  logic [3:0]  shMask;
  int          tickNum;

  // Hand-derived active-low patterns, bit 0 = a.
  function automatic logic [6:0] segOf(input logic [3:0] n);
    case (n)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  task automatic pushExp(input logic [3:0] a, input logic [6:0] s, input string nm);
    exp_t e;
    e.an   = a;
    e.seg  = s;
    e.name = nm;
    expQ.push_back(e);
  endtask

  // Expected output of the upcoming scan tick from the bench's own shadow model.
  task automatic pushTick();
    int         idx;
    bit         phaseOn;
    bit         allZero;
    bit         blk;
    logic [3:0] nib;
    idx     = tickNum % 4;
    phaseOn = ((tickNum / 10) % 2) == 0;
    nib     = shVal[idx*4 +: 4];
    allZero = 1'b1;
    for (int j = idx; j < 4; j++) begin
      if (shVal[j*4 +: 4] != 4'd0) allZero = 1'b0;
    end
    blk = (shMask[idx] && !phaseOn) || (blank_lz && idx != 0 && allZero);
    pushExp(~(4'b0001 << idx), blk ? 7'h7F : segOf(nib),
            $sformatf("tick%0d_dig%0d", tickNum, idx));
  endtask

  // Starts and ends on a falling edge with five rising edges to the next scan tick.
  task automatic applyStimulus(input bit doLoad, input logic [15:0] v, input logic [3:0] m,
                               input bit lz, input bit atTick, input int nTicks);
    blank_lz = lz;
    for (int t = 0; t < nTicks; t++) begin
      for (int c = 1; c <= 5; c++) begin
        load = (t == 0) && doLoad && ((atTick && c == 5) || (!atTick && c == 1));
        if (load) begin
          value      = v;
          blink_mask = m;
        end
        if (c == 5) pushTick();
        @(negedge clk);
        if (load) begin
          shVal  = v;
          shMask = m;
        end
        load = 1'b0;
      end
      tickNum++;
    end
  endtask

  task automatic resetDut();
    rst = 1'b1;
    pushExp(4'hF, 7'h7F, "reset_dark");
    reqCount++;
    repeat (2) @(negedge clk);
    rst     = 1'b0;
    shVal   = 16'h0;
    shMask  = 4'h0;
    tickNum = 0;
  endtask

  task automatic checkOutput();
    exp_t e;
    checkCnt++;
    if (expQ.size() == 0) begin
      $display("[TB] FAIL unexpected_output: an=%b seg=%h with nothing expected", an, seg);
    end else begin
      e = expQ.pop_front();
      if (an === e.an && seg === e.seg) passCnt++;
      else $display("[TB] FAIL %s: got an=%b seg=%h, expected an=%b seg=%h",
                    e.name, an, seg, e.an, e.seg);
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (monOn) begin
      if (an !== prevAn || reqSeen != reqCount) begin
        reqSeen = reqCount;
        checkOutput();
      end
      prevAn = an;
    end
  end

  initial begin
    rst        = 1'b0;
    load       = 1'b0;
    value      = 16'h0;
    blink_mask = 4'h0;
    blank_lz   = 1'b0;
    monOn      = 1'b1;
    resetDut();

    $display("[TB] rotation with zero shadow");
    applyStimulus(1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 4);
    $display("[TB] load 1234 and dash digit");
    applyStimulus(1'b1, 16'h1234, 4'h0, 1'b0, 1'b0, 4);
    applyStimulus(1'b1, 16'hA234, 4'h0, 1'b0, 1'b0, 4);
    $display("[TB] leading-zero blanking");
    applyStimulus(1'b1, 16'h0050, 4'h0, 1'b1, 1'b0, 4);
    applyStimulus(1'b1, 16'h0000, 4'h0, 1'b1, 1'b0, 4);
    $display("[TB] blink on digit 0 across both phases");
    applyStimulus(1'b1, 16'h8888, 4'b0001, 1'b0, 1'b0, 20);
    $display("[TB] load coinciding with scan tick");
    applyStimulus(1'b1, 16'h9999, 4'h0, 1'b0, 1'b1, 4);
    $display("[TB] reset mid-frame");
    repeat (2) @(negedge clk);
    resetDut();
    applyStimulus(1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 4);

    repeat (3) @(negedge clk);
    checkCnt++;
    if (expQ.size() == 0) passCnt++;
    else $display("[TB] FAIL queue_drain: %0d expected outputs never seen, required 0", expQ.size());

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule

// File: doc/seg_display_scan.md
Name: seg_display_scan

Overview:
Parametrised multiplexed 7-segment driver, the next generation of the game's 4-digit display path. Scans NUM_DIGITS common-anode digits from one system clock with an internal refresh divider. Adds per-digit blink, leading-zero blanking, tear-free value loading and non-BCD dash display. Sits between game/score logic and the board seg/an pins, replacing the external 500 Hz / 5 Hz divided clocks with clock-enable ticks.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (1..8)
CLK_HZ, 100000000, system clock frequency
REFRESH_HZ, 1000, full-frame refresh rate; scan tick period = CLK_HZ/(REFRESH_HZ*NUM_DIGITS) cycles
BLINK_HZ, 2, blink frequency; blink phase toggles every CLK_HZ/(2*BLINK_HZ) cycles

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
value  input  4*NUM_DIGITS  BCD digits; nibble 0 = rightmost digit
load  input  1  one-cycle strobe; captures value and blink_mask into shadow registers
blink_mask  input  NUM_DIGITS  1 = digit blinks (blanked during off phase)
blank_lz  input  1  1 = blank leading zeros
seg  output  7  segments, active-low, seg[0]=a .. seg[6]=g
an  output  NUM_DIGITS  anodes, active-low, one-hot-low when lit

Behaviour:
- One clock; reset is synchronous and active-high on rst, sampled on rising clk.
- Reset: seg=7'h7F, an=all ones, scan index=0, scan/blink counters=0, blink phase=ON, shadow value=0, shadow mask=0.
- Elaboration check: both divisor results must be >=1; otherwise $error.
- Scan counter counts 0..SCAN_DIV-1; scan tick on terminal count; index advances, wrapping NUM_DIGITS-1 -> 0.
- Blink counter counts 0..BLINK_DIV-1; phase toggles on terminal count. Runs independently of scan.
- Outputs registered: seg/an reflect the new index one cycle after the scan tick; never more than one anode low.
- Digit decode: 0-9 standard patterns; nibble A-F -> dash (7'b0111111).
- Blanking (seg=7'h7F, anode still driven): blink_mask bit set and phase OFF; or blank_lz=1 and the digit is a leading zero (all higher digits zero). Digit 0 is never LZ-blanked, so value 0 shows "0".
- load captures into shadow on that edge; the display uses shadow only, so no mid-frame tearing. load coinciding with a scan tick: the tick's output uses the old shadow, and the new shadow appears from the next output update.
- blank_lz is used live (unregistered control).
- rst mid-frame: all state returns to reset values on the next edge, and the display is dark until the first scan tick.

Optional Feature:
SEG_DP_EN: adds input dp[NUM_DIGITS-1:0] (captured on load) and output dp_n (active-low), driven with the same timing and blink blanking as seg. Without it, there are no dp ports and no decimal-point logic.

Decomposition:
- Package seg_pkg: SEG_BLANK (7'h7F), SEG_DASH (7'b0111111), the 16-entry pattern constant, and a function bcd_to_seg(nibble).
- One natural sub-module, seg_decoder: combinational nibble -> seg, instanced once on the muxed digit.
- Divider counters stay inline.

Test Plan:
- Reset with CLK_HZ=1000, REFRESH_HZ=50, NUM_DIGITS=4: seg=7'h7F, an=4'hF; first scan tick at cycle 5 -> an=4'b1110 one cycle later; an rotates 1110,1101,1011,0111,1110 every 5 cycles.
- load value=16'h1234: digit0 seg=bcd(4), digit3 seg=bcd(1); value nibble 'hA shows 7'b0111111.
- blank_lz=1, value=16'h0050: digits 3 and 2 are 7'h7F, digit1=bcd(5), digit0=bcd(0); value=0 shows only digit0 "0".
- BLINK_HZ=10, blink_mask=4'b0001: digit0 is blank during alternate 50-cycle windows; other digits are unaffected.
- load asserted on the same cycle as a scan tick: that output shows the old value, and the next digit shows the new value; no partial-frame mixing afterwards.
- rst asserted mid-frame: the next cycle gives seg=7'h7F, an=all ones, index 0; the scan resumes 5 cycles after release.
